// File: rtl/datapath_ctrl.sv
// Purpose: sequences LOAD/ADD/READ/NOP commands onto the 4-bit accumulator datapath and returns one response per command.
// Latency: NOP/READ 1 cycle after accept, LOAD 3, ADD 1+2*(cnt+1).
// Backpressure: single command in flight; cmd_ready low until the response handshake completes, response held stable while rsp_ready is low.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/cmd_data/cmd_cnt carry the command
//   rsp_valid/rsp_ready   response handshake; rsp_data/rsp_carry/rsp_err carry the result
//   ABus, SelB, LoadAC, AddAlu   datapath control lines
//   OutBus                accumulator read-back from the datapath
module datapath_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [WIDTH-1:0] ABus,
    output logic             SelB,
    output logic             LoadAC,
    output logic             AddAlu,
    input  logic [WIDTH-1:0] OutBus
);

    typedef enum logic [1:0] {IDLE, EXEC, CHECK, RESP} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               init_q, init_d;   // AC holds a defined value
    logic [WIDTH-1:0]   prev_q, prev_d;   // AC value before the current EXEC

    // Ungated output values; reset forces every output low below.
    logic               cmd_ready_c, rsp_valid_c, rsp_carry_c, rsp_err_c;
    logic               sel_b_c, load_ac_c, add_alu_c;
    logic [WIDTH-1:0]   rsp_data_c, abus_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            init_q  <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            init_q  <= init_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        init_d      = init_q;
        prev_d      = prev_q;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_data_c  = '0;
        rsp_carry_c = 1'b0;
        rsp_err_c   = 1'b0;
        abus_c      = '0;
        sel_b_c     = 1'b0;
        load_ac_c   = 1'b0;
        add_alu_c   = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = cmd_cnt;
                    carry_d = 1'b0;
                    state_d = (cmd_op == OP_LOAD || cmd_op == OP_ADD) ? EXEC : RESP;
                end
            end
            EXEC: begin
                abus_c    = data_q;
                load_ac_c = 1'b1;
                if (op_q == OP_ADD) begin
                    sel_b_c   = 1'b1;
                    add_alu_c = 1'b1;
                end
                prev_d  = OutBus;
                state_d = CHECK;
            end
            CHECK: begin
                // A modular add of a value below 2^WIDTH wrapped iff the result shrank.
                if (op_q == OP_ADD && OutBus < prev_q) begin
                    carry_d = 1'b1;
                end
                if (op_q == OP_LOAD) begin
                    init_d = 1'b1;
                end
                if (op_q == OP_ADD && cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = EXEC;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                rsp_data_c  = init_q ? OutBus : '0;
                rsp_carry_c = carry_q;
                rsp_err_c   = (op_q == OP_LOAD) ? 1'b0 : ~init_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While reset is held every output is low, so LoadAC drops in the
    // same cycle reset arrives and the datapath AC is not disturbed further.
    assign cmd_ready = cmd_ready_c & ~reset;
    assign rsp_valid = rsp_valid_c & ~reset;
    assign rsp_data  = reset ? '0 : rsp_data_c;
    assign rsp_carry = rsp_carry_c & ~reset;
    assign rsp_err   = rsp_err_c & ~reset;
    assign ABus      = reset ? '0 : abus_c;
    assign SelB      = sel_b_c & ~reset;
    assign LoadAC    = load_ac_c & ~reset;
    assign AddAlu    = add_alu_c & ~reset;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Purpose: self-checking bench for datapath_ctrl with a behavioural accumulator datapath and a response scoreboard.
// Latency: checks first rsp_valid cycle against the command's expected latency.
// Backpressure: exercises rsp_ready held low with a competing command pulse.
module tb_datapath_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_cnt;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry;
    logic          rsp_err;
    logic [W-1:0]  ABus;
    logic          SelB;
    logic          LoadAC;
    logic          AddAlu;
    logic [W-1:0]  OutBus;

    datapath_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .ABus      (ABus),
        .SelB      (SelB),
        .LoadAC    (LoadAC),
        .AddAlu    (AddAlu),
        .OutBus    (OutBus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural accumulator datapath (no reset, like the real one).
    logic [W-1:0] ac = '0;
    always @(posedge clock) begin
        if (LoadAC) ac <= SelB ? ac + ABus : ABus;
    end
    assign OutBus = ac;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         err;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [W-1:0] m_ac   = '0;
    logic         m_init = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] d,
                             input logic [CW-1:0] c, output exp_t e);
        logic [W:0] s;
        e.carry = 1'b0;
        e.err   = 1'b0;
        case (op)
            OP_LOAD: begin
                m_ac   = d;
                m_init = 1'b1;
                e.lat  = 3;
            end
            OP_ADD: begin
                for (int i = 0; i <= int'(c); i++) begin
                    s = {1'b0, m_ac} + {1'b0, d};
                    if (s[W]) e.carry = 1'b1;
                    m_ac = s[W-1:0];
                end
                e.err = ~m_init;
                e.lat = 1 + 2 * (int'(c) + 1);
            end
            default: begin
                e.err = ~m_init;
                e.lat = 1;
            end
        endcase
        e.data = m_init ? m_ac : '0;
    endtask

    // Waits (bounded) for cmd_ready, presents the command for one accept edge,
    // pushes the expectation, and returns the accept cycle index.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d,
                        input logic [CW-1:0] c, input exp_t e, output int k);
        int t = 0;
        @(negedge clock);
        while (!cmd_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = c;
        k = cyc;
        exp_q.push_back(e);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d,
                           input logic [CW-1:0] c, input int hold);
        exp_t e, got_e;
        int k, n;
        logic [63:0] ld_m, sel_m, add_m, exp_m;
        ld_m  = '0;
        sel_m = '0;
        add_m = '0;
        exp_m = '0;
        model_cmd(op, d, c, e);
        rsp_ready = (hold == 0);
        send(op, d, c, e, k);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (!rsp_valid) begin
                ld_m[n]  = LoadAC;
                sel_m[n] = SelB;
                add_m[n] = AddAlu;
                if (LoadAC) chk("abus_operand", 32'(ABus), 32'(d));
            end
        end while (!rsp_valid && n < 40);
        chk("rsp_latency", cyc - k, e.lat);

        if (op == OP_LOAD) exp_m[1] = 1'b1;
        if (op == OP_ADD) begin
            for (int i = 0; i <= int'(c); i++) exp_m[2*i+1] = 1'b1;
        end
        chk("loadac_seq", ld_m[31:0], exp_m[31:0]);
        chk("selb_seq",   sel_m[31:0], (op == OP_ADD) ? exp_m[31:0] : 32'h0);
        chk("addalu_seq", add_m[31:0], (op == OP_ADD) ? exp_m[31:0] : 32'h0);

        if (exp_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            got_e = exp_q.pop_front();
            chk("rsp_data",  32'(rsp_data),  32'(got_e.data));
            chk("rsp_carry", 32'(rsp_carry), 32'(got_e.carry));
            chk("rsp_err",   32'(rsp_err),   32'(got_e.err));
        end

        for (int h = 0; h < hold; h++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_data",  32'(rsp_data),  32'(e.data));
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            cmd_valid = 1'b1;
            cmd_op    = OP_READ;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        exp_t e;
        int   k;
        logic seen_rsp;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cmd_cnt   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_loadac",    32'(LoadAC), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_abus",      32'(ABus), 0);
        chk("post_rst_ctrl",      32'({SelB, LoadAC, AddAlu, rsp_valid}), 0);

        run_cmd(OP_READ, 4'd0, 3'd5, 0);   // uninitialised: data 0, err 1
        run_cmd(OP_LOAD, 4'd5, 3'd0, 0);
        run_cmd(OP_ADD,  4'd3, 3'd0, 0);   // 8
        run_cmd(OP_ADD,  4'd7, 3'd2, 0);   // 15, 6 (wrap), 13
        run_cmd(OP_LOAD, 4'd9, 3'd7, 0);   // cnt ignored for LOAD
        run_cmd(OP_READ, 4'd0, 3'd0, 0);
        run_cmd(OP_NOP,  4'd0, 3'd0, 0);
        run_cmd(OP_ADD,  4'd0, 3'd1, 0);   // add zero never wraps
        run_cmd(OP_LOAD, 4'd4, 3'd0, 4);   // response back-pressure

        // Reset during the second EXEC of ADD cnt=3.
        model_cmd(OP_ADD, 4'd1, 3'd3, e);
        rsp_ready = 1'b1;
        send(OP_ADD, 4'd1, 3'd3, e, k);
        repeat (3) @(negedge clock);
        chk("mid_exec2_cycle", cyc - k, 3);
        chk("mid_exec2_loadac", 32'(LoadAC), 1);
        reset = 1'b1;
        #1;
        chk("mid_loadac_drop", 32'(LoadAC), 0);
        @(negedge clock);
        chk("mid_outs_zero", 32'({cmd_ready, rsp_valid, rsp_carry, rsp_err, SelB, LoadAC, AddAlu}), 0);
        chk("mid_abus_zero", 32'(ABus), 0);
        reset = 1'b0;
        void'(exp_q.pop_back());
        m_init   = 1'b0;
        seen_rsp = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (rsp_valid || LoadAC) seen_rsp = 1'b1;
        end
        chk("mid_no_rsp", 32'(seen_rsp), 0);
        run_cmd(OP_READ, 4'd0, 3'd0, 0);   // err 1 after reset
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Control-side counterpart to the 4-bit accumulator datapath.
- Accepts commands over a valid/ready interface and drives the datapath control lines: ABus, SelB, LoadAC, AddAlu.
- Reads the accumulator back on OutBus and returns one response per command, carrying the result, a carry flag and an error flag.
- Sits between the test/stimulus source and the datapath. Gives the datapath a single sequenced, observable access point.

Parameters:
- WIDTH, 4, data width of ABus/OutBus/cmd_data/rsp_data.
- CNT_W, 3, width of the ADD repeat-count field.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 NOP, 01 LOAD, 10 ADD, 11 READ
- cmd_data  input  WIDTH  operand
- cmd_cnt  input  CNT_W  ADD repeat count; the add is performed cmd_cnt+1 times
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumer ready
- rsp_data  output  WIDTH  accumulator value at command completion
- rsp_carry  output  1  at least one add in this command wrapped modulo 2^WIDTH
- rsp_err  output  1  accumulator was not yet initialised
- ABus  output  WIDTH  operand to the datapath
- SelB  output  1  0 selects ABus (load), 1 selects ABus+AC (add)
- LoadAC  output  1  accumulator write enable
- AddAlu  output  1  high during add cycles
- OutBus  input  WIDTH  accumulator value from the datapath

Behaviour:
- **Reset.** All outputs are 0. State goes to IDLE. The repeat counter, the latched operand/op, the carry flag and ac_init are cleared. The datapath AC has no reset; ac_init tracks whether AC holds a defined value.
- **States:** IDLE, EXEC, CHECK, RESP.
- **IDLE.**
  - cmd_ready=1. All other outputs are 0.
  - A command is accepted on an edge where cmd_valid & cmd_ready.
  - On accept, latch op, data and cnt, and clear carry.
  - LOAD/ADD go to EXEC. NOP/READ go to RESP.
- **EXEC** (exactly one cycle).
  - ABus = latched data, LoadAC = 1.
  - LOAD: SelB=0, AddAlu=0. ADD: SelB=1, AddAlu=1.
  - Before the edge, capture OutBus as prev. AC updates at the end of this cycle.
  - Go to CHECK.
- **CHECK** (one cycle).
  - LoadAC=0. OutBus now shows the new AC.
  - ADD: carry |= (OutBus < prev).
  - LOAD sets ac_init=1.
  - If the op is ADD and the remaining count ≠ 0: decrement the count and go to EXEC. Otherwise go to RESP.
- **RESP.**
  - rsp_valid=1; rsp_data=OutBus; rsp_carry=carry.
  - rsp_err = ~ac_init for NOP/READ/ADD. rsp_err is 0 for LOAD.
  - If rsp_data is unknown (ac_init=0), drive rsp_data=0.
  - Outputs stay stable while rsp_valid & ~rsp_ready.
  - The handshake completes on rsp_valid & rsp_ready. The next cycle returns to IDLE. cmd_ready first rises the cycle after the handshake.
- **ADD before initialisation.** An ADD issued while ac_init=0 still executes, and rsp_err=1.
- **Latency** (accept edge at cycle k):
  - NOP/READ: rsp_valid from cycle k+1.
  - LOAD: rsp_valid from cycle k+3.
  - ADD with cnt=c: rsp_valid from cycle k+1+2(c+1).
- **Arithmetic.** Modulo 2^WIDTH, matching the datapath adder. Carry is sticky across repeats within one command and cleared per command.
- **Throughput.** Only one command is in flight. cmd_ready=0 in EXEC, CHECK and RESP.
- **Reset mid-command.** Return to IDLE on the next edge. LoadAC drops immediately with the reset edge. Any pending response is discarded. ac_init=0, because AC may hold a partial result.
- **Unused ports.** cmd_cnt is ignored for NOP, LOAD and READ.

Test Plan:
- Reset, then LOAD 5 accepted at cycle k:
  - LoadAC=1, SelB=0, ABus=5 in cycle k+1.
  - rsp_valid at k+3 with rsp_data=5, carry=0, err=0.
- AC=5, ADD data=3 cnt=0:
  - SelB=1, AddAlu=1 for one cycle.
  - Response data=8, carry=0, at k+3.
- AC=8, ADD data=7 cnt=2:
  - Sequence 15, 6 (wrap), 13.
  - Response data=13, carry=1, at k+7.
  - Three LoadAC pulses separated by one low cycle.
- READ immediately after reset: response at k+1 with data=0, err=1. Then LOAD 9 and READ: data=9, err=0.
- Response back-pressure: after LOAD 4, hold rsp_ready=0 for 4 cycles.
  - rsp_valid, rsp_data=4 and cmd_ready=0 stay stable.
  - cmd_valid pulsed meanwhile is not accepted.
  - Release rsp_ready: IDLE the next cycle.
- Reset asserted during the second EXEC of an ADD cnt=3:
  - All outputs are 0 the following cycle and no response is issued.
  - A subsequent READ returns err=1.
